mult_share_arbiter: RTL

- Round-robin arbiter that shares one sequential Booth multiplier between NREQ requesters.
- Captures the winning requester's operands and pulses the multiplier start.
- Waits for the multiplier's ready, then returns the product with a one-hot done pulse.
- Sits between client blocks and the multiplier top level. Clients never drive the multiplier directly.

---
 rtl/mult_share_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin front end that shares one sequential multiplier among NREQ clients.
// Optional watchdog: define MULT_ARB_TIMEOUT_EN to enable the WAIT-state timeout.

module mult_share_arbiter #(
   parameter int DW      = 4,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_multiplicand,
   input  logic [NREQ*DW-1:0] req_multiplier,
   output logic [NREQ-1:0]    grant,
   output logic [NREQ-1:0]    done,
   output logic [2*DW-1:0]    result,
   output logic               busy,
   output logic               mul_start,
   output logic [DW-1:0]      mul_multiplicand,
   output logic [DW-1:0]      mul_multiplier,
   input  logic               mul_ready,
   input  logic [2*DW-1:0]    mul_product,
   output logic               err
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   if (NREQ < 2 || NREQ > 8 || DW < 1 || TIMEOUT < 1) begin : g_cfg_check
      $error("mult_share_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_d;
   logic [IW-1:0]   last;
   logic [IW-1:0]   last_d;
   logic [IW-1:0]   idx;
   logic [IW-1:0]   idx_d;
   logic [NREQ-1:0] grant_d;
   logic [NREQ-1:0] done_d;
   logic [2*DW-1:0] result_d;
   logic            mul_start_d;
   logic [DW-1:0]   mcand_d;
   logic [DW-1:0]   mplier_d;

   logic            hit;
   logic [IW-1:0]   pick;
   logic [IW-1:0]   cand;

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_d;
   logic            err_d;
`endif

   assign busy = (state != S_IDLE);

   // Search starts just above the last served index and wraps around.
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = IW'((int'(last) + k) % NREQ);
         if (!hit && req[cand]) begin
            hit  = 1'b1;
            pick = cand;
         end
      end
   end

   always_comb begin
      state_d     = state;
      last_d      = last;
      idx_d       = idx;
      grant_d     = grant;
      done_d      = '0;
      result_d    = result;
      mul_start_d = 1'b0;
      mcand_d     = mul_multiplicand;
      mplier_d    = mul_multiplier;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_d       = cnt;
      err_d       = 1'b0;
`endif

      unique case (state)
         S_IDLE: begin
            if (hit) begin
               idx_d          = pick;
               mcand_d        = req_multiplicand[int'(pick)*DW +: DW];
               mplier_d       = req_multiplier[int'(pick)*DW +: DW];
               grant_d        = '0;
               grant_d[pick]  = 1'b1;
               mul_start_d    = 1'b1;
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // A ready still high from the previous job is not looked at here.
            state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         S_WAIT: begin
            if (mul_ready) begin
               result_d    = mul_product;
               done_d[idx] = 1'b1;
               grant_d     = '0;
               state_d     = S_DONE;
            end
`ifdef MULT_ARB_TIMEOUT_EN
            else if (cnt == CW'(TIMEOUT - 1)) begin
               result_d    = '0;
               done_d[idx] = 1'b1;
               grant_d     = '0;
               err_d       = 1'b1;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
`endif
         end
         S_DONE: begin
            last_d  = idx;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= S_IDLE;
         last             <= IW'(NREQ - 1);
         idx              <= '0;
         grant            <= '0;
         done             <= '0;
         result           <= '0;
         mul_start        <= 1'b0;
         mul_multiplicand <= '0;
         mul_multiplier   <= '0;
      end else begin
         state            <= state_d;
         last             <= last_d;
         idx              <= idx_d;
         grant            <= grant_d;
         done             <= done_d;
         result           <= result_d;
         mul_start        <= mul_start_d;
         mul_multiplicand <= mcand_d;
         mul_multiplier   <= mplier_d;
      end
   end

`ifdef MULT_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         cnt <= cnt_d;
         err <= err_d;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
